// File: rtl/cpu_pkg.sv
// Shared constants and types for the 10-bit pipelined CPU.
// Stages 3, 4 and 5 use the same widths and register-zero encoding.
package cpu_pkg;

  localparam int DATA_W   = 10;
  localparam int SEL_W    = 3;
  localparam int NUM_REGS = 2 ** SEL_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [SEL_W-1:0]  rsel_t;

  localparam rsel_t REG_ZERO = 3'd0;

endpackage : cpu_pkg

// File: rtl/regfile_8x10.sv
// 8 x 10-bit register file.
// Provides one write port and two read ports with write-first bypass.
// R0 is hardwired to zero on both read ports.
module regfile_8x10
  import cpu_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  we_i,
  input  rsel_t waddr_i,
  input  data_t wdata_i,
  input  rsel_t raddr_a_i,
  input  rsel_t raddr_b_i,
  output data_t rdata_a_o,
  output data_t rdata_b_o
);

  data_t mem_q [NUM_REGS];

  // Array update: synchronous clear on reset, otherwise a single write per cycle.
  // we_i already excludes R0, so entry 0 only ever holds zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port A: R0 forced to zero, then bypass of the value committing this cycle.
  always_comb begin
    rdata_a_o = mem_q[raddr_a_i];
    if (raddr_a_i == REG_ZERO) begin
      rdata_a_o = '0;
    end else if (we_i && (raddr_a_i == waddr_i)) begin
      rdata_a_o = wdata_i;
    end
  end

  // Read port B: same rule as port A, so both ports agree on any shared register.
  always_comb begin
    rdata_b_o = mem_q[raddr_b_i];
    if (raddr_b_i == REG_ZERO) begin
      rdata_b_o = '0;
    end else if (we_i && (raddr_b_i == waddr_i)) begin
      rdata_b_o = wdata_i;
    end
  end

endmodule : regfile_8x10

// File: rtl/stage5_writeback.sv
// Stage 5 (write-back) of the 10-bit pipelined CPU.
// Selects memory or ALU result, commits it to the register file, serves
// decode reads with bypass, holds the last write for stage-3 forwarding
// and counts retired instructions with a saturating counter.
module stage5_writeback
  import cpu_pkg::*;
#(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  data_t               mem_res_in,
  input  data_t               ALU_result_in,
  input  logic                reg_write_en_in,
  input  logic                MemtoReg_in,
  input  logic                PC_en_in,
  input  rsel_t               reg_writesel_in,
  input  rsel_t               rs_sel,
  input  rsel_t               rt_sel,
  output data_t               rs_data,
  output data_t               rt_data,
  output data_t               wb_data_out,
  output rsel_t               wb_sel_out,
  output logic                wb_valid_out,
  output logic [RETIRE_W-1:0] retire_count
);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [RETIRE_W-1:0] sat_inc(input logic [RETIRE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  data_t               wb_data;
  logic                commit;
  data_t               wb_data_q;
  rsel_t               wb_sel_q;
  logic                wb_valid_q;
  logic [RETIRE_W-1:0] retire_q;
  logic [RETIRE_W-1:0] retire_d;

  assign wb_data = MemtoReg_in ? mem_res_in : ALU_result_in;

  // Reset in the commit term keeps the bypass from exposing a write that reset will discard.
  assign commit = reset & PC_en_in & reg_write_en_in & (reg_writesel_in != REG_ZERO);

  regfile_8x10 u_regfile (
    .clk_i     (clk),
    .rst_ni    (reset),
    .we_i      (commit),
    .waddr_i   (reg_writesel_in),
    .wdata_i   (wb_data),
    .raddr_a_i (rs_sel),
    .raddr_b_i (rt_sel),
    .rdata_a_o (rs_data),
    .rdata_b_o (rt_data)
  );

  // Next retire count: only advancing instructions count.
  always_comb begin
    retire_d = retire_q;
    if (PC_en_in) begin
      retire_d = sat_inc(retire_q);
    end
  end

  // Forward register and retire counter; data/select update every cycle, valid qualifies them.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wb_data_q  <= '0;
      wb_sel_q   <= '0;
      wb_valid_q <= 1'b0;
      retire_q   <= '0;
    end else begin
      wb_data_q  <= wb_data;
      wb_sel_q   <= reg_writesel_in;
      wb_valid_q <= commit;
      retire_q   <= retire_d;
    end
  end

  assign wb_data_out  = wb_data_q;
  assign wb_sel_out   = wb_sel_q;
  assign wb_valid_out = wb_valid_q;
  assign retire_count = retire_q;

endmodule : stage5_writeback

// File: tb/tb_stage5_writeback.sv
// Directed testbench for stage5_writeback.
module tb_stage5_writeback;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  data_t       mem_res_in;
  data_t       ALU_result_in;
  logic        reg_write_en_in;
  logic        MemtoReg_in;
  logic        PC_en_in;
  rsel_t       reg_writesel_in;
  rsel_t       rs_sel;
  rsel_t       rt_sel;
  data_t       rs_data;
  data_t       rt_data;
  data_t       wb_data_out;
  rsel_t       wb_sel_out;
  logic        wb_valid_out;
  logic [15:0] retire_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stage5_writeback #(.RETIRE_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_res_in      (mem_res_in),
    .ALU_result_in   (ALU_result_in),
    .reg_write_en_in (reg_write_en_in),
    .MemtoReg_in     (MemtoReg_in),
    .PC_en_in        (PC_en_in),
    .reg_writesel_in (reg_writesel_in),
    .rs_sel          (rs_sel),
    .rt_sel          (rt_sel),
    .rs_data         (rs_data),
    .rt_data         (rt_data),
    .wb_data_out     (wb_data_out),
    .wb_sel_out      (wb_sel_out),
    .wb_valid_out    (wb_valid_out),
    .retire_count    (retire_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pc, input logic we, input logic m2r,
                       input data_t mem, input data_t alu, input rsel_t sel);
    PC_en_in        = pc;
    reg_write_en_in = we;
    MemtoReg_in     = m2r;
    mem_res_in      = mem;
    ALU_result_in   = alu;
    reg_writesel_in = sel;
  endtask

  initial begin
    // 1: reset held for two cycles with an active write request
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 10'h000, 10'h3FF, 3'd4);
    rs_sel = 3'd4;
    rt_sel = 3'd4;
    tick();
    tick();
    chk("rst_valid", 32'(wb_valid_out), 32'h0);
    chk("rst_count", 32'(retire_count), 32'h0);
    chk("rst_wbdata", 32'(wb_data_out), 32'h0);
    chk("rst_wbsel", 32'(wb_sel_out), 32'h0);
    for (int i = 1; i < 8; i++) begin
      rs_sel = rsel_t'(i);
      rt_sel = rsel_t'(i);
      #1;
      chk("rst_rs", 32'(rs_data), 32'h0);
      chk("rst_rt", 32'(rt_data), 32'h0);
    end

    // 2: ALU write to R5 with same-cycle bypass
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 10'h000, 10'h003, 3'd5);
    rs_sel = 3'd5;
    rt_sel = 3'd6;
    #1;
    chk("alu_bypass_rs", 32'(rs_data), 32'h003);
    chk("alu_bypass_rt_other", 32'(rt_data), 32'h0);
    tick();
    chk("alu_valid", 32'(wb_valid_out), 32'h1);
    chk("alu_wbsel", 32'(wb_sel_out), 32'h5);
    chk("alu_wbdata", 32'(wb_data_out), 32'h003);
    chk("alu_count", 32'(retire_count), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 3'd5);
    #1;
    chk("alu_array_rs", 32'(rs_data), 32'h003);

    // 3: memory write to R1, both read ports on R1
    drive(1'b1, 1'b1, 1'b1, 10'h01F, 10'h3FF, 3'd1);
    rs_sel = 3'd1;
    rt_sel = 3'd1;
    #1;
    chk("mem_bypass_rs", 32'(rs_data), 32'h01F);
    chk("mem_bypass_rt", 32'(rt_data), 32'h01F);
    tick();
    chk("mem_wbdata", 32'(wb_data_out), 32'h01F);
    chk("mem_count", 32'(retire_count), 32'h2);
    drive(1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 3'd1);
    #1;
    chk("mem_array_rs", 32'(rs_data), 32'h01F);
    chk("mem_array_rt", 32'(rt_data), 32'h01F);
    rt_sel = 3'd5;
    #1;
    chk("r5_kept", 32'(rt_data), 32'h003);

    // 4a: write to R0 is dropped but still retires
    drive(1'b1, 1'b1, 1'b0, 10'h000, 10'h2AA, 3'd0);
    rs_sel = 3'd0;
    rt_sel = 3'd0;
    #1;
    chk("r0_bypass", 32'(rs_data), 32'h0);
    tick();
    chk("r0_valid", 32'(wb_valid_out), 32'h0);
    chk("r0_wbdata_upd", 32'(wb_data_out), 32'h2AA);
    chk("r0_count", 32'(retire_count), 32'h3);
    chk("r0_read", 32'(rt_data), 32'h0);

    // 4b: stalled write to R2 changes nothing
    drive(1'b0, 1'b1, 1'b0, 10'h000, 10'h123, 3'd2);
    rs_sel = 3'd2;
    #1;
    chk("stall_nobypass", 32'(rs_data), 32'h0);
    tick();
    chk("stall_valid", 32'(wb_valid_out), 32'h0);
    chk("stall_count", 32'(retire_count), 32'h3);
    chk("stall_r2", 32'(rs_data), 32'h0);

    // 4c: advancing non-writing instruction counts but is not valid
    drive(1'b1, 1'b0, 1'b0, 10'h000, 10'h055, 3'd6);
    tick();
    chk("nowr_valid", 32'(wb_valid_out), 32'h0);
    chk("nowr_count", 32'(retire_count), 32'h4);

    // 5: R3=155, then reset on the same edge as a write of 0AA to R3
    drive(1'b1, 1'b1, 1'b0, 10'h000, 10'h155, 3'd3);
    tick();
    chk("r3_count", 32'(retire_count), 32'h5);
    drive(1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 3'd3);
    rs_sel = 3'd3;
    rt_sel = 3'd1;
    #1;
    chk("r3_set", 32'(rs_data), 32'h155);
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 10'h000, 10'h0AA, 3'd3);
    #1;
    chk("rst_gates_bypass", 32'(rs_data), 32'h155);
    tick();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 3'd3);
    #1;
    chk("mid_rst_r3", 32'(rs_data), 32'h0);
    chk("mid_rst_r1", 32'(rt_data), 32'h0);
    chk("mid_rst_count", 32'(retire_count), 32'h0);
    chk("mid_rst_valid", 32'(wb_valid_out), 32'h0);
    // first commit after release is accepted
    drive(1'b1, 1'b1, 1'b0, 10'h000, 10'h0AA, 3'd3);
    tick();
    drive(1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 3'd3);
    #1;
    chk("post_rst_r3", 32'(rs_data), 32'h0AA);
    chk("post_rst_valid", 32'(wb_valid_out), 32'h1);
    chk("post_rst_count", 32'(retire_count), 32'h1);

    // 6: counter saturation
    reset = 1'b0;
    tick();
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 10'h000, 10'h000, 3'd0);
    repeat (65534) tick();
    chk("sat_pre", 32'(retire_count), 32'hFFFE);
    tick();
    chk("sat_hit", 32'(retire_count), 32'hFFFF);
    tick();
    chk("sat_hold1", 32'(retire_count), 32'hFFFF);
    tick();
    chk("sat_hold2", 32'(retire_count), 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_stage5_writeback
